// File: rtl/i2s_receive.sv
// i2s_receive: slave-mode I2S receiver clocked by CLK_50.
// BCK/LRCK/DIN are synchronised, BCK rising edges are detected, and 24-bit left/right samples
// are shifted in MSB-first from 32-bit left-justified slots (LRCK high = left).
// Optional BCK watchdog (link_lost) is built when I2S_RX_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module i2s_receive #(
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned SLOT_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
    input  logic                  CLK_50,
    input  logic                  nRST,
    input  logic                  enable,
    input  logic                  BCK_IN,
    input  logic                  LRCK_IN,
    input  logic                  DIN,
    output logic [DATA_WIDTH-1:0] left_audio_out,
    output logic [DATA_WIDTH-1:0] right_audio_out,
    output logic                  sample_valid,
    output logic                  frame_error,
    output logic                  link_lost
);

    localparam int unsigned BitW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        StIdle, StWaitLeft, StShiftL, StSkipL, StShiftR, StSkipR
    } state_e;

    logic [SYNC_STAGES-1:0] bck_sync_q, lr_sync_q, din_sync_q;
    logic                   bck_prev_q, evt_q, lr_evt_q, din_evt_q;
    logic                   evt2_q, ss_q, lr2_q, din2_q, lr_prev_q;

    state_e                 state_q;
    logic [5:0]             slot_cnt_q;
    logic [BitW-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-1:0]  shift_l_q, shift_r_q, left_hold_q;
    logic [DATA_WIDTH-1:0]  left_q, right_q;
    logic                   valid_q, ferr_q;

    logic                   len_bad, pol_bad, slot_err, wd_trip;

    // Synchronisers, BCK edge detect and event-time sampling of LRCK/DIN.
    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            bck_sync_q <= '0;
            lr_sync_q  <= '0;
            din_sync_q <= '0;
            bck_prev_q <= 1'b0;
            evt_q      <= 1'b0;
            lr_evt_q   <= 1'b0;
            din_evt_q  <= 1'b0;
            evt2_q     <= 1'b0;
            ss_q       <= 1'b0;
            lr2_q      <= 1'b0;
            din2_q     <= 1'b0;
            lr_prev_q  <= 1'b0;
        end else begin
            bck_sync_q <= {bck_sync_q[SYNC_STAGES-2:0], BCK_IN};
            lr_sync_q  <= {lr_sync_q[SYNC_STAGES-2:0], LRCK_IN};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], DIN};
            bck_prev_q <= bck_sync_q[SYNC_STAGES-1];
            evt_q      <= bck_sync_q[SYNC_STAGES-1] & ~bck_prev_q;
            lr_evt_q   <= lr_sync_q[SYNC_STAGES-1];
            din_evt_q  <= din_sync_q[SYNC_STAGES-1];
            evt2_q     <= evt_q;
            if (evt_q) begin
                // Slot start is any change of LRCK between consecutive BCK events.
                ss_q      <= lr_evt_q ^ lr_prev_q;
                lr_prev_q <= lr_evt_q;
                lr2_q     <= lr_evt_q;
                din2_q    <= din_evt_q;
            end
        end
    end

    // Framing checks evaluated on a slot start.
    always_comb begin
        len_bad = (state_q != StIdle) && (slot_cnt_q != 6'(SLOT_WIDTH));
        unique case (state_q)
            StSkipL:            pol_bad = lr2_q;
            StSkipR:            pol_bad = ~lr2_q;
            StShiftL, StShiftR: pol_bad = 1'b1;
            default:            pol_bad = 1'b0;
        endcase
        slot_err = evt2_q && ss_q && (len_bad || pol_bad);
    end

`ifdef I2S_RX_TIMEOUT_EN
    logic [7:0] wd_q;
    logic       lost_q;

    assign wd_trip   = !evt2_q && (wd_q == 8'd63);
    assign link_lost = lost_q;

    // Watchdog: cycles since the last BCK event; flags loss once the count reaches 64.
    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            wd_q   <= 8'd0;
            lost_q <= 1'b0;
        end else if (evt2_q) begin
            wd_q   <= 8'd0;
            lost_q <= 1'b0;
        end else begin
            if (wd_q != 8'hFF) wd_q <= wd_q + 8'd1;
            if (wd_trip) lost_q <= 1'b1;
        end
    end
`else
    assign wd_trip   = 1'b0;
    assign link_lost = 1'b0;
`endif

    // Receive FSM with slot counter, shift registers and registered outputs.
    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            state_q     <= StIdle;
            slot_cnt_q  <= 6'd0;
            bit_cnt_q   <= '0;
            shift_l_q   <= '0;
            shift_r_q   <= '0;
            left_hold_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (evt2_q) begin
                if (ss_q)                    slot_cnt_q <= 6'd1;
                else if (slot_cnt_q != 6'd63) slot_cnt_q <= slot_cnt_q + 6'd1;
            end

            if (!enable) begin
                state_q   <= StIdle;
                bit_cnt_q <= '0;
                shift_l_q <= '0;
                shift_r_q <= '0;
            end else if (state_q == StIdle) begin
                state_q <= StWaitLeft;
            end else if (wd_trip) begin
                state_q   <= StWaitLeft;
                bit_cnt_q <= '0;
            end else if (evt2_q && ss_q) begin
                ferr_q <= slot_err;
                // After an error the new slot is judged as if waiting for a left slot.
                if (slot_err || state_q == StWaitLeft || state_q == StSkipR) begin
                    if (lr2_q) begin
                        state_q   <= StShiftL;
                        shift_l_q <= DATA_WIDTH'(din2_q);
                        bit_cnt_q <= BitW'(1);
                    end else begin
                        state_q <= StWaitLeft;
                    end
                end else begin
                    state_q   <= StShiftR;
                    shift_r_q <= DATA_WIDTH'(din2_q);
                    bit_cnt_q <= BitW'(1);
                end
            end else if (evt2_q) begin
                if (state_q == StShiftL) begin
                    shift_l_q <= {shift_l_q[DATA_WIDTH-2:0], din2_q};
                    if (bit_cnt_q == BitW'(DATA_WIDTH - 1)) begin
                        left_hold_q <= {shift_l_q[DATA_WIDTH-2:0], din2_q};
                        state_q     <= StSkipL;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BitW'(1);
                    end
                end else if (state_q == StShiftR) begin
                    shift_r_q <= {shift_r_q[DATA_WIDTH-2:0], din2_q};
                    if (bit_cnt_q == BitW'(DATA_WIDTH - 1)) begin
                        left_q  <= left_hold_q;
                        right_q <= {shift_r_q[DATA_WIDTH-2:0], din2_q};
                        valid_q <= 1'b1;
                        state_q <= StSkipR;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BitW'(1);
                    end
                end
            end
        end
    end

    assign left_audio_out  = left_q;
    assign right_audio_out = right_q;
    assign sample_valid    = valid_q;
    assign frame_error     = ferr_q;

endmodule
